// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants for the pipeline control-word chain.
// Field positions, default width and the bubble word.
package pipe_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam int CTRL_OPCODE_LSB = 0;
    localparam int CTRL_OPCODE_W   = 4;
    localparam int CTRL_AM         = 4;
    localparam int CTRL_S          = 6;
    localparam int CTRL_LOAD       = 7;
    localparam int CTRL_RF         = 8;
    localparam int CTRL_SIZE       = 9;
    localparam int CTRL_RW         = 11;
    localparam int CTRL_EN         = 12;
    localparam int CTRL_B          = 13;
    localparam int CTRL_BL         = 14;

    localparam logic [DEFAULT_WIDTH-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_stage.sv
// pipe_ctrl_stage: one control-word register with valid bit.
// Clear beats load; a word loaded with valid low is forced to zero.
module pipe_ctrl_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             R,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    // Register with reset/clear to bubble, load, otherwise keep.
    always_ff @(posedge clk) begin
        if (R || clear) begin
            q       <= WIDTH'(CTRL_BUBBLE);
            q_valid <= 1'b0;
        end else if (load) begin
            q       <= d_valid ? d : WIDTH'(CTRL_BUBBLE);
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: ID/EX..MEM/WB control-word chain with hold/flush/stall.
// Optional PIPE_CTRL_STATS_EN adds saturating bubble and flush counters.
module pipe_ctrl_chain
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int DEPTH        = 3,
    parameter int FLUSH_STAGES = 1
) (
    input  logic                   clk,
    input  logic                   R,
    input  logic [WIDTH-1:0]       in_ctrl,
    input  logic                   in_valid,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   hold,
    output logic [DEPTH*WIDTH-1:0] stage_ctrl,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [WIDTH-1:0]       out_ctrl,
    output logic                   out_valid
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [15:0]            bubble_count,
    output logic [15:0]            flush_count
`endif
);

    logic [WIDTH-1:0] d_word [DEPTH];
    logic             d_vld  [DEPTH];
    logic [WIDTH-1:0] q_word [DEPTH];
    logic             q_vld  [DEPTH];
    logic             ld     [DEPTH];
    logic             clr    [DEPTH];

    // Per-stage decode: hold > flush > stall > advance.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ld[k]  = 1'b0;
            clr[k] = 1'b0;
            priority case (1'b1)
                hold: ;
                flush: begin
                    if (k < FLUSH_STAGES) clr[k] = 1'b1;
                    else                  ld[k]  = 1'b1;
                end
                stall: begin
                    if (k == 0) clr[k] = 1'b1;
                    else        ld[k]  = 1'b1;
                end
                default: ld[k] = 1'b1;
            endcase
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign d_word[k] = in_ctrl;
            assign d_vld[k]  = in_valid;
        end else begin : g_body
            assign d_word[k] = q_word[k-1];
            assign d_vld[k]  = q_vld[k-1];
        end

        pipe_ctrl_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk    (clk),
            .R      (R),
            .load   (ld[k]),
            .clear  (clr[k]),
            .d      (d_word[k]),
            .d_valid(d_vld[k]),
            .q      (q_word[k]),
            .q_valid(q_vld[k])
        );

        assign stage_ctrl[k*WIDTH +: WIDTH] = q_word[k];
        assign stage_valid[k]               = q_vld[k];
    end

    assign out_ctrl  = q_word[DEPTH-1];
    assign out_valid = q_vld[DEPTH-1];

`ifdef PIPE_CTRL_STATS_EN
    logic bubble_ev;
    logic flush_ev;

    assign bubble_ev = !hold && (flush || stall || !in_valid);
    assign flush_ev  = !hold && flush;

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (R) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (bubble_ev && bubble_count != 16'hFFFF)
                bubble_count <= bubble_count + 16'd1;
            if (flush_ev && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule
